// File: rtl/cmd_decoder_if.sv
// cmd_decoder_if: byte-stream receive, FIFO write bus and frame status bundle.
//   master side (host/RX + FIFOs) drives rx_data, rx_valid, full_bus.
//   slave side (decoder) drives rx_ready, wr_data, wrreq_bus, frame_dst, frame_len,
//   frame_ok, crc_err, addr_err, timeout_err.
interface cmd_decoder_if #(
  parameter int unsigned N_DST = 56
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [N_DST-1:0] full_bus;
  logic [7:0]       wr_data;
  logic [N_DST-1:0] wrreq_bus;
  logic [7:0]       frame_dst;
  logic [7:0]       frame_len;
  logic             frame_ok;
  logic             crc_err;
  logic             addr_err;
  logic             timeout_err;
  modport master (
    output rx_data, rx_valid, full_bus,
    input  rx_ready, wr_data, wrreq_bus, frame_dst, frame_len,
    input  frame_ok, crc_err, addr_err, timeout_err
  );
  modport slave (
    input  rx_data, rx_valid, full_bus,
    output rx_ready, wr_data, wrreq_bus, frame_dst, frame_len,
    output frame_ok, crc_err, addr_err, timeout_err
  );
endinterface

// File: rtl/cmd_decoder.sv
// cmd_decoder: parses PREFIX,DST,LEN,DATA[LEN],CRC frames and steers payload to per-destination FIFOs.
//   clk, rst : clock, synchronous active-high reset
//   dec_if   : slave modport of cmd_decoder_if
//              rx_data/rx_valid/rx_ready : byte input handshake
//              full_bus                  : per-destination FIFO full (needs one slot of margin)
//              wr_data/wrreq_bus         : registered one-hot payload write
//              frame_dst/frame_len       : DST/LEN of last completed or aborted frame
//              frame_ok/crc_err/addr_err/timeout_err : 1-cycle status pulses
//   Optional: define RX_TIMEOUT_EN to abort a frame after TIMEOUT_CYC idle cycles.
module cmd_decoder #(
  parameter int unsigned N_DST       = 56,
  parameter logic [7:0]  PREFIX      = 8'hAA,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input logic         clk,
  input logic         rst,
  cmd_decoder_if.slave dec_if
);
  typedef enum logic [2:0] {HUNT, ADDR, LEN, DATA, CRC} state_t;
  state_t           state_q, state_d;
  logic [7:0]       dst_q, dst_d, len_q, len_d, cnt_q, cnt_d, crc_q, crc_d;
  logic [7:0]       wr_data_q, wr_data_d, frame_dst_q, frame_dst_d, frame_len_q, frame_len_d;
  logic [N_DST-1:0] wrreq_q, wrreq_d, dst_oh;
  logic             ok_q, ok_d, crc_err_q, crc_err_d, addr_err_q, addr_err_d, to_q, to_d;
  logic             dst_ok, rdy, accept, tmo;
  // Out-of-range DST shifts the one bit out, so an empty one-hot marks an invalid address.
  assign dst_oh = {{(N_DST-1){1'b0}}, 1'b1} << dst_q;
  assign dst_ok = |dst_oh;
  assign rdy    = !rst && !(state_q == DATA && |(dst_oh & dec_if.full_bus));
  assign accept = dec_if.rx_valid && rdy;
`ifdef RX_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;
  logic        idle;
  // A stalled byte (valid while backpressured) is not idle time.
  assign idle   = state_q != HUNT && !dec_if.rx_valid;
  assign tmo    = idle && idle_q == TIMEOUT_CYC - 1;
  assign idle_d = (accept || state_q == HUNT || tmo) ? '0 : idle ? idle_q + 32'd1 : idle_q;
  always_ff @(posedge clk) idle_q <= rst ? '0 : idle_d;
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_d     = state_q;
    dst_d       = dst_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    wr_data_d   = wr_data_q;
    wrreq_d     = '0;
    frame_dst_d = frame_dst_q;
    frame_len_d = frame_len_q;
    ok_d        = 1'b0;
    crc_err_d   = 1'b0;
    addr_err_d  = 1'b0;
    to_d        = 1'b0;
    if (tmo) begin
      state_d     = HUNT;
      to_d        = 1'b1;
      frame_dst_d = dst_q;
      frame_len_d = len_q;
    end else if (accept) begin
      case (state_q)
        HUNT: state_d = dec_if.rx_data == PREFIX ? ADDR : HUNT;
        ADDR: begin
          dst_d   = dec_if.rx_data;
          crc_d   = dec_if.rx_data;
          state_d = LEN;
        end
        LEN: begin
          len_d   = dec_if.rx_data;
          crc_d   = crc_q + dec_if.rx_data;
          cnt_d   = '0;
          state_d = dec_if.rx_data == 8'd0 ? CRC : DATA;
        end
        DATA: begin
          crc_d     = crc_q + dec_if.rx_data;
          cnt_d     = cnt_q + 8'd1;
          wr_data_d = dst_ok ? dec_if.rx_data : wr_data_q;
          wrreq_d   = dst_oh;
          state_d   = cnt_q == len_q - 8'd1 ? CRC : DATA;
        end
        CRC: begin
          ok_d        = dst_ok && dec_if.rx_data == crc_q;
          crc_err_d   = dst_ok && dec_if.rx_data != crc_q;
          addr_err_d  = !dst_ok;
          frame_dst_d = dst_q;
          frame_len_d = len_q;
          state_d     = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      dst_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      crc_q       <= '0;
      wr_data_q   <= '0;
      wrreq_q     <= '0;
      frame_dst_q <= '0;
      frame_len_q <= '0;
      ok_q        <= 1'b0;
      crc_err_q   <= 1'b0;
      addr_err_q  <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      wr_data_q   <= wr_data_d;
      wrreq_q     <= wrreq_d;
      frame_dst_q <= frame_dst_d;
      frame_len_q <= frame_len_d;
      ok_q        <= ok_d;
      crc_err_q   <= crc_err_d;
      addr_err_q  <= addr_err_d;
      to_q        <= to_d;
    end
  end
  assign dec_if.rx_ready    = rdy;
  assign dec_if.wr_data     = wr_data_q;
  assign dec_if.wrreq_bus   = wrreq_q;
  assign dec_if.frame_dst   = frame_dst_q;
  assign dec_if.frame_len   = frame_len_q;
  assign dec_if.frame_ok    = ok_q;
  assign dec_if.crc_err     = crc_err_q;
  assign dec_if.addr_err    = addr_err_q;
  assign dec_if.timeout_err = to_q;
endmodule

// File: tb/tb_cmd_decoder.sv
// tb_cmd_decoder: table-driven and directed-sequence checks of cmd_decoder.
module tb_cmd_decoder;
  localparam int N = 56;
  localparam logic [N-1:0] W5 = 56'h20;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cmd_decoder_if #(.N_DST(N)) dif();
  cmd_decoder #(.N_DST(N), .PREFIX(8'hAA), .TIMEOUT_CYC(16)) dut (.clk(clk), .rst(rst), .dec_if(dif.slave));
  typedef struct {
    logic [7:0] d;
    logic       v;
    logic       f;
    logic       rdy;
    logic       wr;
    logic [7:0] wd;
    logic [3:0] st;
    logic [7:0] fd;
    logic [7:0] fl;
  } vec_t;
  vec_t tbl[$];
  int n_vec = 0;
  int n_miss = 0;
  logic [3:0] st_w;
  assign st_w = {dif.frame_ok, dif.crc_err, dif.addr_err, dif.timeout_err};
  function automatic vec_t mk(input logic [7:0] d, input logic v, input logic f, input logic rdy,
                              input logic wr, input logic [7:0] wd, input logic [3:0] st,
                              input logic [7:0] fd, input logic [7:0] fl);
    vec_t r;
    r.d = d; r.v = v; r.f = f; r.rdy = rdy; r.wr = wr; r.wd = wd; r.st = st; r.fd = fd; r.fl = fl;
    return r;
  endfunction
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_vec++;
    if (a !== e) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic step(input logic [7:0] d, input logic v, input logic [N-1:0] f, output logic rdy);
    @(negedge clk);
    dif.rx_data = d;
    dif.rx_valid = v;
    dif.full_bus = f;
    #1 rdy = dif.rx_ready;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic wr, input string n);
    logic r;
    step(d, 1'b1, '0, r);
    chk({n, " rdy"}, 64'(r), 64'(1));
    chk({n, " wrreq"}, 64'(dif.wrreq_bus), 64'(wr ? W5 : '0));
    if (wr) chk({n, " wr_data"}, 64'(dif.wr_data), 64'(d));
  endtask
  task automatic good_frame(input string n);
    send(8'hAA, 1'b0, n);
    send(8'h05, 1'b0, n);
    send(8'h03, 1'b0, n);
    send(8'h11, 1'b1, n);
    send(8'h22, 1'b1, n);
    send(8'h33, 1'b1, n);
    send(8'h6E, 1'b0, n);
    chk({n, " status"}, 64'(st_w), 64'(4'b1000));
    chk({n, " frame_dst"}, 64'(dif.frame_dst), 64'(8'h05));
    chk({n, " frame_len"}, 64'(dif.frame_len), 64'(8'h03));
  endtask
  initial begin
    logic r;
    logic [7:0] crc;
    dif.rx_data = '0;
    dif.rx_valid = 1'b0;
    dif.full_bus = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rdy in reset", 64'(dif.rx_ready), 64'(0));
    rst = 1'b0;
    #1;
    chk("rdy after reset", 64'(dif.rx_ready), 64'(1));
    chk("wrreq reset", 64'(dif.wrreq_bus), 64'(0));
    chk("wr_data reset", 64'(dif.wr_data), 64'(0));
    chk("status reset", 64'(st_w), 64'(0));
    chk("frame_dst reset", 64'(dif.frame_dst), 64'(0));
    chk("frame_len reset", 64'(dif.frame_len), 64'(0));
    // good frame
    tbl.push_back(mk(8'hAA, 1, 0, 1, 0, 8'h00, 4'h0, 8'h00, 8'h00));
    tbl.push_back(mk(8'h05, 1, 0, 1, 0, 8'h00, 4'h0, 8'h00, 8'h00));
    tbl.push_back(mk(8'h03, 1, 0, 1, 0, 8'h00, 4'h0, 8'h00, 8'h00));
    tbl.push_back(mk(8'h11, 1, 0, 1, 1, 8'h11, 4'h0, 8'h00, 8'h00));
    tbl.push_back(mk(8'h22, 1, 0, 1, 1, 8'h22, 4'h0, 8'h00, 8'h00));
    tbl.push_back(mk(8'h33, 1, 0, 1, 1, 8'h33, 4'h0, 8'h00, 8'h00));
    tbl.push_back(mk(8'h6E, 1, 0, 1, 0, 8'h00, 4'h8, 8'h05, 8'h03));
    tbl.push_back(mk(8'h00, 0, 0, 1, 0, 8'h00, 4'h0, 8'h05, 8'h03));
    // bad crc
    tbl.push_back(mk(8'hAA, 1, 0, 1, 0, 8'h00, 4'h0, 8'h05, 8'h03));
    tbl.push_back(mk(8'h05, 1, 0, 1, 0, 8'h00, 4'h0, 8'h05, 8'h03));
    tbl.push_back(mk(8'h03, 1, 0, 1, 0, 8'h00, 4'h0, 8'h05, 8'h03));
    tbl.push_back(mk(8'h11, 1, 0, 1, 1, 8'h11, 4'h0, 8'h05, 8'h03));
    tbl.push_back(mk(8'h22, 1, 0, 1, 1, 8'h22, 4'h0, 8'h05, 8'h03));
    tbl.push_back(mk(8'h33, 1, 0, 1, 1, 8'h33, 4'h0, 8'h05, 8'h03));
    tbl.push_back(mk(8'h6F, 1, 0, 1, 0, 8'h00, 4'h4, 8'h05, 8'h03));
    // garbage then zero-length frame
    tbl.push_back(mk(8'h00, 1, 0, 1, 0, 8'h00, 4'h0, 8'h05, 8'h03));
    tbl.push_back(mk(8'h7F, 1, 0, 1, 0, 8'h00, 4'h0, 8'h05, 8'h03));
    tbl.push_back(mk(8'hAA, 1, 0, 1, 0, 8'h00, 4'h0, 8'h05, 8'h03));
    tbl.push_back(mk(8'h09, 1, 0, 1, 0, 8'h00, 4'h0, 8'h05, 8'h03));
    tbl.push_back(mk(8'h00, 1, 0, 1, 0, 8'h00, 4'h0, 8'h05, 8'h03));
    tbl.push_back(mk(8'h09, 1, 0, 1, 0, 8'h00, 4'h8, 8'h09, 8'h00));
    // invalid dst with every FIFO full: still ready, no writes
    tbl.push_back(mk(8'hAA, 1, 1, 1, 0, 8'h00, 4'h0, 8'h09, 8'h00));
    tbl.push_back(mk(8'h40, 1, 1, 1, 0, 8'h00, 4'h0, 8'h09, 8'h00));
    tbl.push_back(mk(8'h02, 1, 1, 1, 0, 8'h00, 4'h0, 8'h09, 8'h00));
    tbl.push_back(mk(8'h01, 1, 1, 1, 0, 8'h00, 4'h0, 8'h09, 8'h00));
    tbl.push_back(mk(8'h02, 1, 1, 1, 0, 8'h00, 4'h0, 8'h09, 8'h00));
    tbl.push_back(mk(8'h45, 1, 1, 1, 0, 8'h00, 4'h2, 8'h40, 8'h02));
    // gaps and PREFIX as payload
    tbl.push_back(mk(8'hAA, 1, 0, 1, 0, 8'h00, 4'h0, 8'h40, 8'h02));
    tbl.push_back(mk(8'h05, 1, 0, 1, 0, 8'h00, 4'h0, 8'h40, 8'h02));
    tbl.push_back(mk(8'h02, 1, 0, 1, 0, 8'h00, 4'h0, 8'h40, 8'h02));
    tbl.push_back(mk(8'h00, 0, 0, 1, 0, 8'h00, 4'h0, 8'h40, 8'h02));
    tbl.push_back(mk(8'hAA, 1, 0, 1, 1, 8'hAA, 4'h0, 8'h40, 8'h02));
    tbl.push_back(mk(8'h00, 0, 0, 1, 0, 8'h00, 4'h0, 8'h40, 8'h02));
    tbl.push_back(mk(8'h01, 1, 0, 1, 1, 8'h01, 4'h0, 8'h40, 8'h02));
    tbl.push_back(mk(8'hB2, 1, 0, 1, 0, 8'h00, 4'h8, 8'h05, 8'h02));
    // one stalled byte
    tbl.push_back(mk(8'hAA, 1, 0, 1, 0, 8'h00, 4'h0, 8'h05, 8'h02));
    tbl.push_back(mk(8'h05, 1, 0, 1, 0, 8'h00, 4'h0, 8'h05, 8'h02));
    tbl.push_back(mk(8'h01, 1, 0, 1, 0, 8'h00, 4'h0, 8'h05, 8'h02));
    tbl.push_back(mk(8'h77, 1, 1, 0, 0, 8'h00, 4'h0, 8'h05, 8'h02));
    tbl.push_back(mk(8'h77, 1, 0, 1, 1, 8'h77, 4'h0, 8'h05, 8'h02));
    tbl.push_back(mk(8'h7D, 1, 0, 1, 0, 8'h00, 4'h8, 8'h05, 8'h01));
    foreach (tbl[i]) begin
      step(tbl[i].d, tbl[i].v, {N{tbl[i].f}}, r);
      chk($sformatf("v%0d rdy", i), 64'(r), 64'(tbl[i].rdy));
      chk($sformatf("v%0d wrreq", i), 64'(dif.wrreq_bus), 64'(tbl[i].wr ? W5 : '0));
      if (tbl[i].wr) chk($sformatf("v%0d wr_data", i), 64'(dif.wr_data), 64'(tbl[i].wd));
      chk($sformatf("v%0d status", i), 64'(st_w), 64'(tbl[i].st));
      chk($sformatf("v%0d frame_dst", i), 64'(dif.frame_dst), 64'(tbl[i].fd));
      chk($sformatf("v%0d frame_len", i), 64'(dif.frame_len), 64'(tbl[i].fl));
    end
    // 10 cycles of full on destination 5 mid-payload
    send(8'hAA, 1'b0, "bp");
    send(8'h05, 1'b0, "bp");
    send(8'h03, 1'b0, "bp");
    send(8'h11, 1'b1, "bp");
    for (int k = 0; k < 10; k++) begin
      step(8'h22, 1'b1, W5, r);
      chk("bp stall rdy", 64'(r), 64'(0));
      chk("bp stall wrreq", 64'(dif.wrreq_bus), 64'(0));
    end
    send(8'h22, 1'b1, "bp");
    send(8'h33, 1'b1, "bp");
    send(8'h6E, 1'b0, "bp");
    chk("bp status", 64'(st_w), 64'(4'b1000));
    // reset mid-frame
    send(8'hAA, 1'b0, "mid rst");
    send(8'h05, 1'b0, "mid rst");
    send(8'h02, 1'b0, "mid rst");
    send(8'h11, 1'b1, "mid rst");
    @(negedge clk);
    rst = 1'b1;
    dif.rx_valid = 1'b0;
    #1 chk("mid rst rdy", 64'(dif.rx_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid rst wrreq", 64'(dif.wrreq_bus), 64'(0));
    chk("mid rst status", 64'(st_w), 64'(0));
    chk("mid rst frame_dst", 64'(dif.frame_dst), 64'(0));
    chk("mid rst frame_len", 64'(dif.frame_len), 64'(0));
    for (int k = 0; k < 3; k++) begin
      step(8'h00, 1'b0, '0, r);
      chk("post rst status", 64'(st_w), 64'(0));
      chk("post rst wrreq", 64'(dif.wrreq_bus), 64'(0));
    end
    good_frame("after rst");
    // LEN=255
    send(8'hAA, 1'b0, "len255");
    send(8'h05, 1'b0, "len255");
    send(8'hFF, 1'b0, "len255");
    crc = 8'h05 + 8'hFF;
    for (int i = 0; i < 255; i++) begin
      send(8'(i), 1'b1, "len255 data");
      chk("len255 no early status", 64'(st_w), 64'(0));
      crc = crc + 8'(i);
    end
    send(crc, 1'b0, "len255");
    chk("len255 status", 64'(st_w), 64'(4'b1000));
    chk("len255 frame_len", 64'(dif.frame_len), 64'(8'hFF));
    // inter-byte silence
    send(8'hAA, 1'b0, "tmo");
    send(8'h05, 1'b0, "tmo");
    send(8'h03, 1'b0, "tmo");
    send(8'h11, 1'b1, "tmo");
    for (int k = 1; k <= 20; k++) begin
      step(8'h00, 1'b0, '0, r);
`ifdef RX_TIMEOUT_EN
      chk($sformatf("tmo cycle %0d", k), 64'(dif.timeout_err), 64'(k == 16));
      if (k == 16) begin
        chk("tmo frame_dst", 64'(dif.frame_dst), 64'(8'h05));
        chk("tmo frame_len", 64'(dif.frame_len), 64'(8'h03));
      end
`else
      chk($sformatf("no tmo cycle %0d", k), 64'(dif.timeout_err), 64'(0));
`endif
    end
`ifdef RX_TIMEOUT_EN
    good_frame("after tmo");
`else
    send(8'h22, 1'b1, "resume");
    send(8'h33, 1'b1, "resume");
    send(8'h6E, 1'b0, "resume");
    chk("resume status", 64'(st_w), 64'(4'b1000));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/cmd_decoder.md
Name: cmd_decoder

Overview:
Receive-side framer, the counterpart of the command encoder. It parses the host byte stream, which has the format PREFIX, DST, LEN, DATA[LEN], CRC. Each payload byte is steered to one of N_DST destination FIFOs through a one-hot write bus. After the CRC byte it reports the frame status. It sits between the UART/USB RX byte interface and the per-peripheral command FIFOs.

Parameters:
N_DST, 56, number of destination addresses; valid DST range is 0..N_DST-1
PREFIX, 8'hAA, frame start byte
TIMEOUT_CYC, 1000, inter-byte timeout in clk cycles (used only with RX_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_data  in  8  incoming byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  decoder can accept a byte; transfer happens when rx_valid & rx_ready
full_bus  in  N_DST  per-destination FIFO full flags
wr_data  out  8  payload byte to the destination FIFO
wrreq_bus  out  N_DST  one-hot write strobe; bit = DST
frame_dst  out  8  DST of the last completed or aborted frame
frame_len  out  8  LEN of the last completed or aborted frame
frame_ok  out  1  1-cycle pulse: frame complete, CRC matched
crc_err  out  1  1-cycle pulse: CRC mismatch
addr_err  out  1  1-cycle pulse: DST >= N_DST; frame consumed, nothing written
timeout_err  out  1  1-cycle pulse: frame aborted on timeout (tied 0 without macro)

Behaviour:
- Reset: clk, synchronous, active-high. On rst all outputs go to 0, except rx_ready, which is 0 during reset and 1 from the first cycle after it. State goes to HUNT; counters and CRC are cleared. Reset mid-frame drops the frame silently: no status pulse, no further writes.
- Accept = rx_valid & rx_ready. State advances only on accept.
- States:
  - HUNT: bytes != PREFIX are discarded. PREFIX -> ADDR.
  - ADDR: latch dst; crc <= byte -> LEN.
  - LEN: latch len; crc <= crc + byte; cnt <= 0. If len == 0 -> CRC, else -> DATA.
  - DATA: crc <= crc + byte; cnt <= cnt + 1. If dst valid, write the byte. If cnt == len-1 -> CRC.
  - CRC: compare byte to crc. Pulse frame_ok or crc_err; if dst was invalid, pulse addr_err instead of either. Update frame_dst/frame_len. -> HUNT.
- CRC arithmetic: 8-bit sum, wrap modulo 256, of DST + LEN + all DATA bytes. The PREFIX is excluded.
- Write timing:
  - wr_data and wrreq_bus are registered: they assert the cycle after the DATA byte is accepted, with exactly one bit set, for 1 cycle.
  - Back-to-back accepts give back-to-back writes.
- Backpressure:
  - In DATA, rx_ready = !full_bus[dst] when dst is valid; it is 1 when dst is invalid.
  - In all other states rx_ready = 1.
  - full_bus is sampled combinationally; the FIFO must assert full with at least one slot of margin to cover the registered write.
- Payload already written is not retracted on crc_err. Consumers qualify data with the status pulse.
- A byte equal to PREFIX inside ADDR/LEN/DATA/CRC is treated as ordinary data; there is no resync.
- Status pulses come 1 cycle after the CRC byte is accepted and are mutually exclusive.
- LEN = 255 gives 255 data bytes; cnt is 8 bits and must not wrap before the compare.

Optional Feature:
RX_TIMEOUT_EN:
- With the macro defined: an idle counter is cleared on every accept and increments each cycle while the state is not HUNT. When it reaches TIMEOUT_CYC-1 the frame is aborted: state -> HUNT, a 1-cycle timeout_err pulse is issued, frame_dst/frame_len are updated, and data already written stays written.
- Cycles where rx_valid=1 but rx_ready=0 (backpressure) do not count as idle.
- Without the macro: no counter, timeout_err is tied to 0, and the decoder waits indefinitely.

Test Plan:
- Good frame: AA 05 03 11 22 33 6E -> wrreq_bus bit5 pulses 3 times with wr_data 11, 22, 33; frame_ok=1 one cycle after the CRC; frame_dst=05, frame_len=03.
- Bad CRC: AA 05 03 11 22 33 6F -> same 3 writes, then crc_err=1 and frame_ok=0.
- Zero length and garbage: 00 7F AA 09 00 09 -> no writes; frame_ok; the leading 00 7F are discarded in HUNT.
- Invalid dst: AA 40 02 01 02 45 (N_DST=56) -> no wrreq_bus activity, addr_err=1, rx_ready stays 1.
- Backpressure: full_bus[5]=1 for 10 cycles mid-payload -> rx_ready=0 for those cycles, no bytes lost, correct frame_ok at the end. Also assert rst mid-frame -> no pulse, and the next frame decodes correctly.
- RX_TIMEOUT_EN, TIMEOUT_CYC=16: AA 05 03 11 followed by silence -> timeout_err at 16 idle cycles, then a full frame decodes correctly.
